// File: rtl/tx_fifo_arbiter.sv
// tx_fifo_arbiter: shares the UART TX FIFO write port between a byte source and a word source.
// Define TX_ARB_FIXED_PRIO_EN to make REQ1 win every tie instead of round-robin.
module tx_fifo_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    REQ0_VALID,
    input  logic [DATA_WIDTH-1:0]   REQ0_DATA,
    output logic                    REQ0_READY,
    input  logic                    REQ1_VALID,
    input  logic [2*DATA_WIDTH-1:0] REQ1_DATA,
    output logic                    REQ1_READY,
    input  logic                    FIFO_FULL,
    output logic                    FIFO_WR,
    output logic [DATA_WIDTH-1:0]   FIFO_DATA,
    output logic                    BUSY
);

    typedef enum logic [1:0] {IDLE, SEND_B, SEND_LO, SEND_HI} state_t;

    state_t                  state;
    state_t                  next_state;
    logic [2*DATA_WIDTH-1:0] hold_reg;
    logic                    grant0;
    logic                    grant1;
    logic                    accept0;
    logic                    accept1;
    logic                    push;

`ifdef TX_ARB_FIXED_PRIO_EN
    assign grant1 = REQ1_VALID;
`else
    // last_served = 1 means REQ1 was accepted most recently, so REQ0 wins the next tie.
    logic last_served;

    assign grant1 = REQ1_VALID & (~REQ0_VALID | ~last_served);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_served <= 1'b0;
        end else if (accept0) begin
            last_served <= 1'b0;
        end else if (accept1) begin
            last_served <= 1'b1;
        end
    end
`endif

    assign grant0     = REQ0_VALID & ~grant1;
    assign accept0    = (state == IDLE) & grant0;
    assign accept1    = (state == IDLE) & grant1;
    assign REQ0_READY = accept0;
    assign REQ1_READY = accept1;
    assign push       = (state != IDLE) & ~FIFO_FULL;
    assign FIFO_WR    = push;
    assign BUSY       = (state != IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            hold_reg <= '0;
        end else begin
            state <= next_state;
            if (accept0) begin
                hold_reg <= {{DATA_WIDTH{1'b0}}, REQ0_DATA};
            end else if (accept1) begin
                hold_reg <= REQ1_DATA;
            end
        end
    end

    always_comb begin
        next_state = state;
        FIFO_DATA  = '0;
        case (state)
            IDLE: begin
                if (accept0) begin
                    next_state = SEND_B;
                end else if (accept1) begin
                    next_state = SEND_LO;
                end
            end
            SEND_B: begin
                FIFO_DATA = hold_reg[DATA_WIDTH-1:0];
                if (push) begin
                    next_state = IDLE;
                end
            end
            SEND_LO: begin
                FIFO_DATA = hold_reg[DATA_WIDTH-1:0];
                if (push) begin
                    next_state = SEND_HI;
                end
            end
            SEND_HI: begin
                FIFO_DATA = hold_reg[2*DATA_WIDTH-1:DATA_WIDTH];
                if (push) begin
                    next_state = IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// tb_tx_fifo_arbiter: directed checks of tx_fifo_arbiter handshakes, byte order, stalls and reset.
// Expectations follow TX_ARB_FIXED_PRIO_EN when the bench is built with it.
module tb_tx_fifo_arbiter;

    logic        CLK;
    logic        RST;
    logic        REQ0_VALID;
    logic [7:0]  REQ0_DATA;
    logic        REQ0_READY;
    logic        REQ1_VALID;
    logic [15:0] REQ1_DATA;
    logic        REQ1_READY;
    logic        FIFO_FULL;
    logic        FIFO_WR;
    logic [7:0]  FIFO_DATA;
    logic        BUSY;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  wr_log[$];

    tx_fifo_arbiter #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_DATA  (REQ0_DATA),
        .REQ0_READY (REQ0_READY),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_DATA  (REQ1_DATA),
        .REQ1_READY (REQ1_READY),
        .FIFO_FULL  (FIFO_FULL),
        .FIFO_WR    (FIFO_WR),
        .FIFO_DATA  (FIFO_DATA),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change just after posedge, so the falling edge sees the settled write for that cycle.
    always @(negedge CLK) begin
        if (FIFO_WR === 1'b1) begin
            wr_log.push_back(FIFO_DATA);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [7:0] d0, input logic v1,
                                 input logic [15:0] d1, input logic full);
        REQ0_VALID = v0;
        REQ0_DATA  = d0;
        REQ1_VALID = v1;
        REQ1_DATA  = d1;
        FIFO_FULL  = full;
    endtask

    task automatic checkPorts(input string tag, input logic r0, input logic r1, input logic wr,
                              input logic [7:0] data, input logic busy);
        checkOutput({tag, ".ready0"}, {15'd0, REQ0_READY}, {15'd0, r0});
        checkOutput({tag, ".ready1"}, {15'd0, REQ1_READY}, {15'd0, r1});
        checkOutput({tag, ".wr"},     {15'd0, FIFO_WR},    {15'd0, wr});
        checkOutput({tag, ".data"},   {8'd0, FIFO_DATA},   {8'd0, data});
        checkOutput({tag, ".busy"},   {15'd0, BUSY},       {15'd0, busy});
    endtask

    // One clock cycle: sample on the falling edge, then move to just after the next rising edge.
    task automatic step(input string tag, input logic r0, input logic r1, input logic wr,
                        input logic [7:0] data, input logic busy);
        @(negedge CLK);
        checkPorts(tag, r0, r1, wr, data, busy);
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] logEntry(input int i);
        if (i < wr_log.size()) begin
            return {8'd0, wr_log[i]};
        end
        return 16'hFFFF;
    endfunction

    task automatic checkLog(input string tag, input int n, input logic [7:0] e0,
                            input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] exp_vals[3];
        exp_vals[0] = e0;
        exp_vals[1] = e1;
        exp_vals[2] = e2;
        checkOutput({tag, ".count"}, 16'(wr_log.size()), 16'(n));
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s.byte%0d", tag, i), logEntry(i), {8'd0, exp_vals[i]});
        end
    endtask

    initial begin
        RST = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);

        // Reset values
        @(negedge CLK);
        checkPorts("reset", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        // REQ0 alone
        wr_log.delete();
        applyStimulus(1'b1, 8'hA5, 1'b0, 16'h0000, 1'b0);
        step("r0_acc", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        step("r0_wr", 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1);
        step("r0_idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkLog("r0_log", 1, 8'hA5, 8'h00, 8'h00);

        // REQ1 alone, low byte first
        wr_log.delete();
        applyStimulus(1'b0, 8'h00, 1'b1, 16'h1234, 1'b0);
        step("r1_acc", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        step("r1_lo", 1'b0, 1'b0, 1'b1, 8'h34, 1'b1);
        step("r1_hi", 1'b0, 1'b0, 1'b1, 8'h12, 1'b1);
        step("r1_idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkLog("r1_log", 2, 8'h34, 8'h12, 8'h00);

        // Tie straight out of reset: REQ1 first, REQ0 waits while busy
        RST = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        wr_log.delete();
        applyStimulus(1'b1, 8'h11, 1'b1, 16'hBEEF, 1'b0);
        step("tie_acc", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h11, 1'b0, 16'h0000, 1'b0);
        step("tie_lo", 1'b0, 1'b0, 1'b1, 8'hEF, 1'b1);
        step("tie_hi", 1'b0, 1'b0, 1'b1, 8'hBE, 1'b1);
        step("tie_r0acc", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        step("tie_b", 1'b0, 1'b0, 1'b1, 8'h11, 1'b1);
        step("tie_idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkLog("tie_log", 3, 8'hEF, 8'hBE, 8'h11);

        // Second tie after REQ1 served: round-robin hands it to REQ0, fixed priority to REQ1
        wr_log.delete();
        applyStimulus(1'b1, 8'h22, 1'b1, 16'h3344, 1'b0);
        step("rr_acc1", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b1, 16'h5566, 1'b0);
        step("rr_lo1", 1'b0, 1'b0, 1'b1, 8'h44, 1'b1);
        step("rr_hi1", 1'b0, 1'b0, 1'b1, 8'h33, 1'b1);
`ifdef TX_ARB_FIXED_PRIO_EN
        step("rr_tie", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0, 16'h0000, 1'b0);
        step("rr_lo2", 1'b0, 1'b0, 1'b1, 8'h66, 1'b1);
        step("rr_hi2", 1'b0, 1'b0, 1'b1, 8'h55, 1'b1);
        step("rr_acc3", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        step("rr_b", 1'b0, 1'b0, 1'b1, 8'h22, 1'b1);
        step("rr_idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        wr_log = wr_log[2:$];
        checkLog("rr_log", 3, 8'h66, 8'h55, 8'h22);
`else
        step("rr_tie", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 16'h5566, 1'b0);
        step("rr_b", 1'b0, 1'b0, 1'b1, 8'h22, 1'b1);
        step("rr_acc3", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        step("rr_lo2", 1'b0, 1'b0, 1'b1, 8'h66, 1'b1);
        step("rr_hi2", 1'b0, 1'b0, 1'b1, 8'h55, 1'b1);
        step("rr_idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        wr_log = wr_log[2:$];
        checkLog("rr_log", 3, 8'h22, 8'h66, 8'h55);
`endif

        // FULL between low and high byte; a REQ0 arriving mid-word must wait
        wr_log.delete();
        applyStimulus(1'b0, 8'h00, 1'b1, 16'hCAFE, 1'b0);
        step("st_acc", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        step("st_lo", 1'b0, 1'b0, 1'b1, 8'hFE, 1'b1);
        applyStimulus(1'b1, 8'h77, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("st_hold%0d", i), 1'b0, 1'b0, 1'b0, 8'hCA, 1'b1);
        end
        applyStimulus(1'b1, 8'h77, 1'b0, 16'h0000, 1'b0);
        step("st_hi", 1'b0, 1'b0, 1'b1, 8'hCA, 1'b1);
        step("st_r0acc", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        step("st_b", 1'b0, 1'b0, 1'b1, 8'h77, 1'b1);
        step("st_idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkLog("st_log", 3, 8'hFE, 8'hCA, 8'h77);

        // Reset while the high byte is pending
        applyStimulus(1'b0, 8'h00, 1'b1, 16'h7788, 1'b0);
        step("rs_acc", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        step("rs_lo", 1'b0, 1'b0, 1'b1, 8'h88, 1'b1);
        checkPorts("rs_pending", 1'b0, 1'b0, 1'b1, 8'h77, 1'b1);
        RST = 1'b0;
        #1;
        checkPorts("rs_async", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        wr_log.delete();
        applyStimulus(1'b1, 8'h5A, 1'b0, 16'h0000, 1'b0);
        step("rs_acc2", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        step("rs_b", 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1);
        step("rs_idle1", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step("rs_idle2", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkLog("rs_log", 1, 8'h5A, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_fifo_arbiter.md
# tx_fifo_arbiter

Write-side arbiter for the UART TX asynchronous FIFO in the REF_CLK domain. It shares the single FIFO write port between two response sources: an 8-bit source for register-file read data and a 16-bit source for ALU results. ALU results are serialized into two bytes, low byte first. The block holds each accepted word until the FIFO accepts every byte of it, stalling on FULL, so bytes are never lost or interleaved.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width of the FIFO word and of REQ0_DATA. REQ1_DATA is 2*DATA_WIDTH.

Ports:
- CLK  in  1  REF_CLK domain clock.
- RST  in  1  asynchronous, active-low reset.
- REQ0_VALID  in  1  byte request from the register-file path.
- REQ0_DATA  in  DATA_WIDTH  byte to transmit.
- REQ0_READY  out  1  request 0 accepted this cycle.
- REQ1_VALID  in  1  word request from the ALU path.
- REQ1_DATA  in  2*DATA_WIDTH  word to transmit, low byte first.
- REQ1_READY  out  1  request 1 accepted this cycle.
- FIFO_FULL  in  1  FULL flag from the FIFO write side.
- FIFO_WR  out  1  write-increment pulse to the FIFO.
- FIFO_DATA  out  DATA_WIDTH  write data to the FIFO.
- BUSY  out  1  a word is held and not yet fully written.

## Operation
- FSM states: IDLE, SEND_B, SEND_LO, SEND_HI. Reset state is IDLE.
- A request is accepted on a clock edge where VALID and READY are both 1. The source must hold VALID and DATA stable until it is accepted.
- Grant logic (combinational):
  - Only in IDLE.
  - REQx_READY = IDLE & REQx_VALID & grant_x.
  - At most one READY is high in any cycle.
  - A lone valid requester is always granted.
  - Tie (both valid): round-robin. The requester not served last wins. A 1-bit last_served register updates on every accept. After reset last_served = 0, so REQ1 wins the first tie.
- Accepting REQ0:
  - Captures REQ0_DATA into hold_reg[7:0].
  - IDLE -> SEND_B.
- Accepting REQ1:
  - Captures REQ1_DATA into hold_reg[15:0].
  - IDLE -> SEND_LO.
- FIFO_DATA mux:
  - SEND_B and SEND_LO: hold_reg[7:0].
  - SEND_HI: hold_reg[15:8].
  - IDLE: 0.
- FIFO_WR = (state != IDLE) & ~FIFO_FULL, combinational. A byte is pushed on each edge where FIFO_WR = 1.
- State transitions on a push:
  - SEND_B -> IDLE.
  - SEND_LO -> SEND_HI.
  - SEND_HI -> IDLE.
- While FIFO_FULL = 1, the state, hold_reg and FIFO_DATA are frozen and FIFO_WR = 0. The stall length is unbounded.
- BUSY = (state != IDLE).

## Timing
- Reset values: FIFO_WR = 0, FIFO_DATA = 0, REQ0_READY = 0, REQ1_READY = 0, BUSY = 0, hold_reg = 0, last_served = 0.
- An accept at edge N gives FIFO_WR = 1 during cycle N+1 when FIFO_FULL = 0.
- REQ1 without stalls: low byte written in cycle N+1, high byte in cycle N+2.
- The next accept can happen in the cycle after the final write, when the state is back to IDLE.
- Maximum throughput:
  - 1 byte per 2 cycles for REQ0.
  - 2 bytes per 3 cycles for REQ1.
- FULL rising between the low and high bytes: the high byte waits in SEND_HI. Bytes are never reordered.
- A new VALID arriving while BUSY is not accepted; READY stays 0 and the source keeps waiting.
- Reset asserted mid-word:
  - Returns to IDLE immediately.
  - Discards any unsent byte.
  - FIFO_WR deasserts asynchronously.

## Configuration
- TX_ARB_FIXED_PRIO_EN
  - Defined: REQ1 always wins ties. last_served is not implemented.
  - Undefined (default): round-robin as described under Operation.

## Test plan
- REQ0 only, data 0xA5, FIFO_FULL = 0: REQ0_READY pulses for 1 cycle; FIFO_WR pulses in the next cycle with FIFO_DATA = 0xA5; BUSY high for 1 cycle.
- REQ1 only, data 0x1234: FIFO writes 0x34 then 0x12 on consecutive cycles; BUSY high for 2 cycles.
- Both valid from reset, REQ0 = 0x11, REQ1 = 0xBEEF, held:
  - Round-robin build: write order EF, BE, 11.
  - With TX_ARB_FIXED_PRIO_EN and REQ1 re-asserted: REQ0 starves while REQ1 stays valid.
- REQ1 = 0xCAFE with FIFO_FULL raised after the low byte for 5 cycles: FE written; no FIFO_WR during the 5 stall cycles; CA written in the cycle FULL drops; FIFO_DATA holds 0xCA throughout the stall.
- RST pulled low while in SEND_HI: all outputs 0 at once; after release, the next REQ0 = 0x5A produces exactly one write of 0x5A and no stale high byte.
